// File: rtl/barrel_shift_pipe.sv
// rtl/barrel_shift_pipe.sv - pipelined ROR/ROL/LSR/ASR shifter, one 2^k step per stage
// Optional out_zero flag enabled by defining BARREL_SHIFT_PIPE_ZERO_FLAG_EN.
module barrel_shift_pipe #(
   parameter int ADDRESS_BITS = 3,
   parameter int TAG_BITS     = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [2**ADDRESS_BITS-1:0] in_num,
   input  logic [ADDRESS_BITS-1:0]   in_amt,
   input  logic [1:0]                in_mode,
   input  logic [TAG_BITS-1:0]       in_tag,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2**ADDRESS_BITS-1:0] out_data,
   output logic [TAG_BITS-1:0]       out_tag
`ifdef BARREL_SHIFT_PIPE_ZERO_FLAG_EN
   ,
   output logic                      out_zero
`endif
);

   localparam int WIDTH = 2**ADDRESS_BITS;
   localparam logic [1:0] MODE_ROR = 2'b00;
   localparam logic [1:0] MODE_ROL = 2'b01;
   localparam logic [1:0] MODE_LSR = 2'b10;
   localparam logic [1:0] MODE_ASR = 2'b11;
   localparam logic [ADDRESS_BITS-1:0] AMT_ZERO = '0;

   logic [ADDRESS_BITS-1:0] valid_q, valid_d;
   logic [WIDTH-1:0]        data_q [ADDRESS_BITS];
   logic [WIDTH-1:0]        data_d [ADDRESS_BITS];
   logic [ADDRESS_BITS-1:0] amt_q  [ADDRESS_BITS];
   logic [ADDRESS_BITS-1:0] amt_d  [ADDRESS_BITS];
   logic [1:0]              mode_q [ADDRESS_BITS];
   logic [1:0]              mode_d [ADDRESS_BITS];
   logic [ADDRESS_BITS-1:0] sign_q, sign_d;
   logic [TAG_BITS-1:0]     tag_q  [ADDRESS_BITS];
   logic [TAG_BITS-1:0]     tag_d  [ADDRESS_BITS];

   logic [ADDRESS_BITS:0]   ready;

   logic [ADDRESS_BITS-1:0] stg_valid;
   logic [WIDTH-1:0]        stg_data [ADDRESS_BITS];
   logic [ADDRESS_BITS-1:0] stg_amt  [ADDRESS_BITS];
   logic [1:0]              stg_mode [ADDRESS_BITS];
   logic [ADDRESS_BITS-1:0] stg_sign;
   logic [TAG_BITS-1:0]     stg_tag  [ADDRESS_BITS];
   logic [WIDTH-1:0]        stepped  [ADDRESS_BITS];

   logic                    unused_bits;

   always_comb begin
      ready[ADDRESS_BITS] = out_ready;
      for (int k = ADDRESS_BITS - 1; k >= 0; k--) begin
         ready[k] = !valid_q[k] || ready[k + 1];
      end
   end

   // Stage 0 sees the prepared operand: ROL folded into ROR, sign latched for ASR.
   always_comb begin
      stg_valid[0] = in_valid;
      stg_data[0]  = in_num;
      stg_tag[0]   = in_tag;
      stg_sign[0]  = (in_mode == MODE_ASR) && in_num[WIDTH-1];
      if (in_mode == MODE_ROL) begin
         stg_amt[0]  = AMT_ZERO - in_amt;
         stg_mode[0] = MODE_ROR;
      end else begin
         stg_amt[0]  = in_amt;
         stg_mode[0] = in_mode;
      end
      for (int k = 1; k < ADDRESS_BITS; k++) begin
         stg_valid[k] = valid_q[k-1];
         stg_data[k]  = data_q[k-1];
         stg_amt[k]   = amt_q[k-1];
         stg_mode[k]  = mode_q[k-1];
         stg_sign[k]  = sign_q[k-1];
         stg_tag[k]   = tag_q[k-1];
      end
   end

   always_comb begin
      valid_d = valid_q;
      sign_d  = sign_q;
      for (int k = 0; k < ADDRESS_BITS; k++) begin
         stepped[k] = stg_data[k];
         if (stg_amt[k][k]) begin
            case (stg_mode[k])
               MODE_LSR: stepped[k] = stg_data[k] >> (1 << k);
               MODE_ASR: stepped[k] = (stg_data[k] >> (1 << k)) |
                                      (stg_sign[k] ? ~({WIDTH{1'b1}} >> (1 << k)) : '0);
               default:  stepped[k] = (stg_data[k] >> (1 << k)) |
                                      (stg_data[k] << (WIDTH - (1 << k)));
            endcase
         end
         data_d[k] = data_q[k];
         amt_d[k]  = amt_q[k];
         mode_d[k] = mode_q[k];
         tag_d[k]  = tag_q[k];
         if (ready[k]) begin
            valid_d[k] = stg_valid[k];
         end
         // Payload only moves with a real item so idle stages keep their contents.
         if (ready[k] && stg_valid[k]) begin
            data_d[k] = stepped[k];
            amt_d[k]  = stg_amt[k];
            mode_d[k] = stg_mode[k];
            sign_d[k] = stg_sign[k];
            tag_d[k]  = stg_tag[k];
         end
      end
   end

   always_comb begin
      unused_bits = 1'b0;
      for (int k = 0; k < ADDRESS_BITS; k++) begin
         unused_bits = unused_bits ^ (^amt_q[k]) ^ (^mode_q[k]) ^ sign_q[k];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         sign_q  <= '0;
         for (int k = 0; k < ADDRESS_BITS; k++) begin
            data_q[k] <= '0;
            amt_q[k]  <= '0;
            mode_q[k] <= '0;
            tag_q[k]  <= '0;
         end
      end else begin
         valid_q <= valid_d;
         sign_q  <= sign_d;
         for (int k = 0; k < ADDRESS_BITS; k++) begin
            data_q[k] <= data_d[k];
            amt_q[k]  <= amt_d[k];
            mode_q[k] <= mode_d[k];
            tag_q[k]  <= tag_d[k];
         end
      end
   end

`ifdef BARREL_SHIFT_PIPE_ZERO_FLAG_EN
   logic zero_q, zero_d;

   always_comb begin
      zero_d = zero_q;
      if (ready[ADDRESS_BITS-1] && stg_valid[ADDRESS_BITS-1]) begin
         zero_d = (stepped[ADDRESS_BITS-1] == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         zero_q <= 1'b0;
      end else begin
         zero_q <= zero_d;
      end
   end

   assign out_zero = zero_q;
`endif

   assign in_ready  = ready[0] && !reset;
   assign out_valid = valid_q[ADDRESS_BITS-1];
   assign out_data  = data_q[ADDRESS_BITS-1];
   assign out_tag   = tag_q[ADDRESS_BITS-1];

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb/tb_barrel_shift_pipe.sv - directed-vector bench for barrel_shift_pipe (ADDRESS_BITS=3, TAG_BITS=4)
module tb_barrel_shift_pipe;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_num;
   logic [2:0] in_amt;
   logic [1:0] in_mode;
   logic [3:0] in_tag;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [3:0] out_tag;
`ifdef BARREL_SHIFT_PIPE_ZERO_FLAG_EN
   logic       out_zero;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [7:0] data;
      logic [3:0] tag;
      logic       zero;
      bit         lat;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];

   barrel_shift_pipe #(.ADDRESS_BITS(3), .TAG_BITS(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_num    (in_num),
      .in_amt    (in_amt),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
`ifdef BARREL_SHIFT_PIPE_ZERO_FLAG_EN
      ,
      .out_zero  (out_zero)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic send(input logic [7:0] n, input logic [2:0] a, input logic [1:0] m,
                       input logic [3:0] t, input logic [7:0] e, input bit lat);
      int   waited;
      exp_t x;
      in_valid = 1'b1;
      in_num   = n;
      in_amt   = a;
      in_mode  = m;
      in_tag   = t;
      #1;
      waited = 0;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!in_ready) begin
         check("send_timeout", in_ready, 1'b1);
      end else begin
         x.data = e;
         x.tag  = t;
         x.zero = (e == 8'h00);
         x.lat  = lat;
         x.cyc  = cyc;
         exp_q.push_back(x);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 30 && exp_q.size() != 0; n++) @(negedge clk);
      @(negedge clk);
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", out_valid, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("out_data", out_data, e.data);
               check("out_tag", out_tag, e.tag);
`ifdef BARREL_SHIFT_PIPE_ZERO_FLAG_EN
               check("out_zero", out_zero, e.zero);
`endif
               if (e.lat) check("latency", cyc - e.cyc, 3);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   accepted;
      logic [7:0] bp_num [5];
      logic [2:0] bp_amt [5];
      logic [1:0] bp_mode[5];
      logic [7:0] bp_exp [5];
      exp_t x;

      reset = 1'b1; in_valid = 1'b0; in_num = '0; in_amt = '0; in_mode = '0; in_tag = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_in_ready_low", in_ready, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_out_tag", out_tag, 4'h0);
      check("rst_in_ready_high", in_ready, 1'b1);
`ifdef BARREL_SHIFT_PIPE_ZERO_FLAG_EN
      check("rst_out_zero", out_zero, 1'b0);
`endif
      @(negedge clk);

      // Four modes back to back, latency checked by the monitor.
      send(8'hB4, 3'd3, 2'b00, 4'd1, 8'h96, 1'b1);
      send(8'hB4, 3'd3, 2'b01, 4'd2, 8'hA5, 1'b1);
      send(8'hB4, 3'd3, 2'b10, 4'd3, 8'h16, 1'b1);
      send(8'hB4, 3'd3, 2'b11, 4'd4, 8'hF6, 1'b1);
      drain();

      // Zero amount and edge amounts.
      send(8'h81, 3'd0, 2'b00, 4'd5, 8'h81, 1'b0);
      send(8'h81, 3'd0, 2'b01, 4'd6, 8'h81, 1'b0);
      send(8'h81, 3'd0, 2'b10, 4'd7, 8'h81, 1'b0);
      send(8'h81, 3'd0, 2'b11, 4'd8, 8'h81, 1'b0);
      send(8'h80, 3'd7, 2'b11, 4'd9, 8'hFF, 1'b0);
      send(8'h80, 3'd7, 2'b10, 4'hA, 8'h01, 1'b0);
      send(8'h80, 3'd1, 2'b01, 4'hB, 8'h01, 1'b0);
      send(8'h01, 3'd5, 2'b01, 4'hC, 8'h20, 1'b0);
      send(8'h01, 3'd1, 2'b00, 4'hD, 8'h80, 1'b0);
      drain();

      // Backpressure: only three items fit while out_ready is low.
      bp_num[0] = 8'hF0; bp_amt[0] = 3'd4; bp_mode[0] = 2'b00; bp_exp[0] = 8'h0F;
      bp_num[1] = 8'h0F; bp_amt[1] = 3'd4; bp_mode[1] = 2'b01; bp_exp[1] = 8'hF0;
      bp_num[2] = 8'hFF; bp_amt[2] = 3'd1; bp_mode[2] = 2'b10; bp_exp[2] = 8'h7F;
      bp_num[3] = 8'h7F; bp_amt[3] = 3'd2; bp_mode[3] = 2'b11; bp_exp[3] = 8'h1F;
      bp_num[4] = 8'h90; bp_amt[4] = 3'd4; bp_mode[4] = 2'b11; bp_exp[4] = 8'hF9;
      out_ready = 1'b0;
      accepted = 0;
      for (int c = 0; c < 6; c++) begin
         in_valid = 1'b1;
         in_num   = bp_num[accepted];
         in_amt   = bp_amt[accepted];
         in_mode  = bp_mode[accepted];
         in_tag   = 4'(accepted + 1);
         #1;
         if (in_ready) begin
            x.data = bp_exp[accepted]; x.tag = 4'(accepted + 1);
            x.zero = (bp_exp[accepted] == 8'h00); x.lat = 1'b0; x.cyc = cyc;
            exp_q.push_back(x);
            accepted++;
         end
         @(negedge clk);
      end
      #1;
      check("bp_accepted", accepted, 3);
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_data", out_data, 8'h0F);
      check("bp_out_tag", out_tag, 4'd1);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("bp_stable_valid", out_valid, 1'b1);
      check("bp_stable_data", out_data, 8'h0F);
      check("bp_stable_tag", out_tag, 4'd1);
      @(negedge clk);
      out_ready = 1'b1;
      send(bp_num[3], bp_amt[3], bp_mode[3], 4'd4, bp_exp[3], 1'b0);
      send(bp_num[4], bp_amt[4], bp_mode[4], 4'd5, bp_exp[4], 1'b0);
      drain();

      // Bubble collapse behind a stalled output.
      out_ready = 1'b0;
      send(8'h01, 3'd1, 2'b01, 4'hA, 8'h02, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #1;
      check("bub_out_valid", out_valid, 1'b1);
      check("bub_ready_1", in_ready, 1'b1);
      @(negedge clk);
      send(8'h80, 3'd7, 2'b00, 4'hB, 8'h01, 1'b0);
      #1;
      check("bub_ready_2", in_ready, 1'b1);
      @(negedge clk);
      send(8'h55, 3'd0, 2'b10, 4'hC, 8'h55, 1'b0);
      #1;
      check("bub_ready_full", in_ready, 1'b0);
      check("bub_out_data_held", out_data, 8'h02);
      @(negedge clk);
      out_ready = 1'b1;
      drain();

      // Reset with three items in flight; none may surface afterwards.
      out_ready = 1'b0;
      send(8'h11, 3'd1, 2'b00, 4'd1, 8'h88, 1'b0);
      send(8'h22, 3'd1, 2'b00, 4'd2, 8'h11, 1'b0);
      send(8'h33, 3'd1, 2'b00, 4'd3, 8'h99, 1'b0);
      reset = 1'b1;
      exp_q.delete();
      #1;
      check("mid_rst_in_ready", in_ready, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_out_data", out_data, 8'h00);
      check("mid_rst_out_tag", out_tag, 4'h0);
      check("mid_rst_in_ready_high", in_ready, 1'b1);
      @(negedge clk);
      out_ready = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      check("mid_rst_no_output", out_valid, 1'b0);
      @(negedge clk);

      // Zero result vs non-zero result.
      send(8'h04, 3'd3, 2'b10, 4'hD, 8'h00, 1'b0);
      send(8'h04, 3'd3, 2'b00, 4'hE, 8'h80, 1'b0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/barrel_shift_pipe.md
# barrel_shift_pipe

- Pipelined, parametrised shifter/rotator with four modes: rotate right, rotate left, logical shift right, arithmetic shift right.
- One shift-by-2^i level per pipeline register, with a valid/ready handshake at each end and per-stage bubble collapse.
- Carries a user tag alongside each operand.
- Sits between an upstream operand producer and the ALU result path, as the throughput-oriented successor to the combinational rotator.

## Interface
Parameters:
- ADDRESS_BITS, 3, shift-amount width; data WIDTH = 2**ADDRESS_BITS; also the pipeline depth.
- TAG_BITS, 4, width of the sideband tag carried unmodified with each operand (minimum 1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand on in_* is valid.
- in_ready  output  1  block accepts the operand this cycle.
- in_num  input  WIDTH  operand.
- in_amt  input  ADDRESS_BITS  shift/rotate amount, 0..WIDTH-1.
- in_mode  input  2  00 ROR, 01 ROL, 10 LSR, 11 ASR.
- in_tag  input  TAG_BITS  sideband, returned with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  shifted/rotated result.
- out_tag  output  TAG_BITS  tag of the result.
- out_zero  output  1  present only with BARREL_SHIFT_PIPE_ZERO_FLAG_EN (see Configuration).

## Operation
- **Transfers:** an input transfer occurs on a rising edge with in_valid && in_ready; an output transfer occurs with out_valid && out_ready.
- **Pipeline structure:** ADDRESS_BITS stages, k = 0..ADDRESS_BITS-1.
  - Each stage holds a valid bit, data, remaining amt, mode and tag.
  - Stage k applies the conditional 2^k step selected by amt bit k, then registers the result.
  - Stage ADDRESS_BITS-1 drives out_*.
- **Mode preparation before stage 0:**
  - ROL is converted to ROR by amt' = (WIDTH - amt) mod WIDTH, using ADDRESS_BITS-bit wraparound arithmetic. ROL by 0 therefore gives amt' = 0.
  - LSR and ASR step fill: vacated high bits are filled with 0 (LSR) or with the operand's original MSB (ASR). The sign bit is captured at entry and carried down the pipeline.
- **Functional results** (n = in_num, a = in_amt):
  - ROR: {n[a-1:0], n[WIDTH-1:a]}
  - ROL: {n[WIDTH-1-a:0], n[WIDTH-1:WIDTH-a]}
  - LSR: n >> a
  - ASR: $signed(n) >>> a
  - a = 0 returns n unchanged in every mode.
- **Flow control:**
  - ready_k = !valid_k || ready_{k+1}, with ready_ADDRESS_BITS = out_ready; in_ready = ready_0.
  - Stage k loads from stage k-1 (or from the input) when ready_k; its valid becomes the upstream valid.
  - Bubbles collapse: an empty stage accepts even while downstream is stalled.
- **Ordering and storage:** results leave in acceptance order. No item is dropped or duplicated. Maximum occupancy is ADDRESS_BITS items.
- **Reset:**
  - Clears every stage valid bit on the edge where reset is sampled high. In-flight items are discarded.
  - out_data, out_tag and out_zero become 0. in_ready is 1 in the first cycle after reset deasserts.
- **Invalid stages:** data registers of invalid stages hold their values (no requirement on contents). out_data and out_tag are only meaningful while out_valid is high, except after reset, when they are 0.

## Timing
- **Latency:** operand presented in cycle c and accepted there appears with out_valid in cycle c+ADDRESS_BITS when no stall occurs (3 cycles at the default).
- **Throughput:** 1 result per cycle under continuous in_valid and out_ready.
- **Readiness path:** in_ready is combinational from out_ready through the valid bits. There is no combinational path from in_* to out_*.
- **Stable output:** out_valid, out_data and out_tag stay stable while out_valid && !out_ready.
- **Simultaneous accept and emit:** with a full pipeline and out_ready high, the pipeline emits and accepts in the same cycle; in_ready = 1.
- **Reset values:** out_valid 0, out_data 0, out_tag 0, out_zero 0; in_ready 0 only while reset is held high, 1 after.

## Configuration
- **BARREL_SHIFT_PIPE_ZERO_FLAG_EN defined:**
  - Adds the out_zero port, registered with the final stage: out_zero = (final result == 0).
  - Valid with out_valid and held under stall.
- **Not defined:** the out_zero port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use ADDRESS_BITS=3, TAG_BITS=4.
- **Modes:** in_num=0xB4, amt=3, modes 00/01/10/11, tags 1..4, back-to-back with out_ready=1 -> out_data 0x96, 0xA5, 0x16, 0xF6 on consecutive cycles c+3..c+6, tags 1..4 in order.
- **Zero amount:** amt=0, all modes, in_num=0x81 -> 0x81 each. ASR amt=7 on 0x80 -> 0xFF. LSR amt=7 on 0x80 -> 0x01.
- **Backpressure:** out_ready=0, offer 5 items -> exactly 3 accepted, in_ready=0 after, out_* stable. Raise out_ready -> the 3 items drain in order, then the remaining 2 are accepted.
- **Bubble collapse:** one item stalled at the output, out_ready=0 -> in_ready stays 1 until stages 0-1 fill as well.
- **Reset mid-operation:** 3 items in flight, assert reset for 1 cycle -> out_valid=0, out_data=0, out_tag=0 next cycle; no discarded item ever appears at the output.
- **Zero flag (with BARREL_SHIFT_PIPE_ZERO_FLAG_EN):** LSR 0x04 by 3 -> out_data 0x00 with out_zero=1; ROR 0x04 by 3 -> 0x80 with out_zero=0.
